// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz), derived totals, sync windows
// and the coordinate type used by the sync generator.
package vga_pkg;

    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam int DEF_CLK_DIV = 4;

    localparam int DEF_H_DISP = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;

    localparam int DEF_V_DISP = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    localparam int DEF_H_TOTAL = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_H_SYNC_START = DEF_H_DISP + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_DISP + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic in_window(input coord_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) <= hi);
    endfunction

endpackage

// File: rtl/divisor_pixel.sv
// Pixel-rate divider: counts system clocks and flags the last one of each
// pixel period.
module divisor_pixel
    import vga_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic CLK,
    input  logic RESET_N,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    // Tick decoded straight from the register so it has no extra latency.
    assign p_tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (p_tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_sincronizador.sv
// VGA sync generator: pixel/line counters, registered sync and blanking
// outputs, and a once-per-frame strobe for tear-free updates.
module vga_sincronizador
    import vga_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FP    = DEF_H_FP,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FP    = DEF_V_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP
) (
    input  logic               CLK,
    input  logic               RESET_N,
    output logic               p_tick,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               frame_end
);

    localparam int H_TOTAL      = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_DISP + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISP + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
            $error("vga_sincronizador: H_TOTAL/V_TOTAL exceed coordinate range");
        end
        if (CLK_DIV < 2) begin : g_bad_div
            $error("vga_sincronizador: CLK_DIV must be at least 2");
        end
    endgenerate

    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   video_q, video_d;
    logic   h_last;
    logic   v_last;

    divisor_pixel #(
        .CLK_DIV (CLK_DIV)
    ) u_divisor_pixel (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .p_tick  (p_tick)
    );

    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    // Sync and blanking are decoded from the next counts so the registered
    // versions line up with the pix_x/pix_y they accompany.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (p_tick) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + coord_t'(1);
            if (h_last) begin
                v_cnt_d = v_last ? '0 : v_cnt_q + coord_t'(1);
            end
        end
        hsync_d = !in_window(h_cnt_d, H_SYNC_START, H_SYNC_END);
        vsync_d = !in_window(v_cnt_d, V_SYNC_START, V_SYNC_END);
        video_d = (int'(h_cnt_d) < H_DISP) && (int'(v_cnt_d) < V_DISP);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b1;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
        end
    end

    assign pix_x     = h_cnt_q;
    assign pix_y     = v_cnt_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_q;
    assign frame_end = p_tick & h_last & v_last;

endmodule

// File: tb/tb_vga_sincronizador.sv
// Self-checking bench for vga_sincronizador: one default-timing instance plus
// two shrunken-timing instances (CLK_DIV 4 and 2) so whole frames fit in a short run.
module tb_vga_sincronizador;

    logic clk = 1'b0;
    logic rstN = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic checkOn = 1'b0;

    logic       aTick, aHs, aVs, aVid, aFe;
    logic [9:0] aX, aY;
    logic       bTick, bHs, bVs, bVid, bFe;
    logic [9:0] bX, bY;
    logic       cTick, cHs, cVs, cVid, cFe;
    logic [9:0] cX, cY;

    logic [24:0] aVec, bVec, cVec;
    assign aVec = {aFe, aTick, aVid, aVs, aHs, aY, aX};
    assign bVec = {bFe, bTick, bVid, bVs, bHs, bY, bX};
    assign cVec = {cFe, cTick, cVid, cVs, cHs, cY, cX};

    localparam logic [24:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};

    vga_sincronizador dutA (
        .CLK(clk), .RESET_N(rstN), .p_tick(aTick), .pix_x(aX), .pix_y(aY),
        .hsync(aHs), .vsync(aVs), .video_on(aVid), .frame_end(aFe)
    );

    vga_sincronizador #(
        .CLK_DIV(4), .H_DISP(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_DISP(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dutB (
        .CLK(clk), .RESET_N(rstN), .p_tick(bTick), .pix_x(bX), .pix_y(bY),
        .hsync(bHs), .vsync(bVs), .video_on(bVid), .frame_end(bFe)
    );

    vga_sincronizador #(
        .CLK_DIV(2), .H_DISP(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_DISP(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dutC (
        .CLK(clk), .RESET_N(rstN), .p_tick(cTick), .pix_x(cX), .pix_y(cY),
        .hsync(cHs), .vsync(cVs), .video_on(cVid), .frame_end(cFe)
    );

    // 100 MHz system clock: rising edges at 5, 15, 25 ... ns.
    always #5 clk = ~clk;

    // Clocks elapsed since the last reset release; the reference model is a
    // pure function of this count.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Reference model: pixel index = ticks elapsed, coordinates by division
    // and modulo, sync/blanking straight from the window definitions.
    function automatic logic [24:0] refModel(input int n, input int d,
                                             input int hd, input int hf, input int hs, input int hb,
                                             input int vd, input int vf, input int vs, input int vb);
        int   ht = hd + hf + hs + hb;
        int   vt = vd + vf + vs + vb;
        int   k  = n / d;
        int   x  = k % ht;
        int   y  = (k / ht) % vt;
        logic tick = ((n % d) == d - 1);
        logic hsN  = !((x >= hd + hf) && (x < hd + hf + hs));
        logic vsN  = !((y >= vd + vf) && (y < vd + vf + vs));
        logic vid  = (x < hd) && (y < vd);
        logic fe   = tick && (x == ht - 1) && (y == vt - 1);
        logic [9:0] xs = 10'(x);
        logic [9:0] ys = 10'(y);
        return {fe, tick, vid, vsN, hsN, ys, xs};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    // Drive reset away from the active edge, then let the design run.
    task automatic applyStimulus(input logic r, input int cycles);
        @(negedge clk);
        #1 rstN = r;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic waitUntil(input int target);
        int guard = 0;
        while (cyc != target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) checkOutput("waitUntil", cyc, target);
    endtask

    task automatic waitFe(input int which, output int at);
        at = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ((which == 1 && bFe) || (which == 2 && cFe)) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Continuous comparison of all three instances against the model.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("modelA", aVec, refModel(cyc, 4, 640, 16, 96, 48, 480, 10, 2, 33));
            checkOutput("modelB", bVec, refModel(cyc, 4, 16, 2, 4, 3, 8, 2, 2, 3));
            checkOutput("modelC", cVec, refModel(cyc, 2, 16, 2, 4, 3, 8, 2, 2, 3));
        end
    end

    initial begin
        #800us;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        int         at;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       tick;
        logic       fe;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int ticks, lastT, badSp, t1, t2;

        tbl[0]  = '{3,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{4,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{2559, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{2560, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{2623, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{2624, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{3007, 10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{3008, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3199, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{3200, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{3204, 10'd1,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset held: every instance shows the reset values.
        #2 rstN = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetA", aVec, RESET_VEC);
        checkOutput("resetB", bVec, RESET_VEC);
        checkOutput("resetC", cVec, RESET_VEC);
        checkOn = 1'b1;

        // Release and walk the default-timing line through its boundaries.
        applyStimulus(1'b1, 0);
        for (int i = 0; i < 11; i++) begin
            waitUntil(tbl[i].at);
            checkOutput($sformatf("line@%0d", tbl[i].at), aVec,
                        {tbl[i].fe, tbl[i].tick, tbl[i].vid, tbl[i].vs, tbl[i].hs, tbl[i].y, tbl[i].x});
        end

        // p_tick count and spacing over 1000 clocks.
        ticks = 0; lastT = -1; badSp = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (aTick) begin
                ticks++;
                if (lastT >= 0 && cyc - lastT != 4) badSp++;
                lastT = cyc;
            end
        end
        checkOutput("tickCount", ticks, 250);
        checkOutput("tickSpacing", badSp, 0);

        // Frame strobe spacing and wrap on the shrunken instances.
        waitFe(1, t1);
        waitFe(1, t2);
        checkOutput("frameSpacingB", t2 - t1, 1500);
        @(negedge clk);
        checkOutput("wrapB", {bY, bX}, 20'd0);
        waitFe(2, t1);
        waitFe(2, t2);
        checkOutput("frameSpacingC", t2 - t1, 750);
        @(negedge clk);
        checkOutput("wrapC", {cY, cX}, 20'd0);

        // Random reset pulses and run lengths; the model keeps checking.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, $urandom_range(1, 4));
            applyStimulus(1'b1, $urandom_range(20, 1500));
        end

        // Reset while both syncs are low on instance B (x=20, y=11).
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 0);
        waitUntil(1181);
        checkOutput("syncLowB", {bHs, bVs, bY, bX}, {1'b0, 1'b0, 10'd11, 10'd20});
        #1 rstN = 1'b0;
        #1;
        checkOutput("asyncResetB", bVec, RESET_VEC);
        checkOutput("asyncResetA", aVec, RESET_VEC);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sincronizador.md
# vga_sincronizador

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock. It drives the pixel coordinates `pix_x` and `pix_y` consumed by the character/text generator, the `hsync`/`vsync` pins, the `video_on` blanking flag used to gate RGB, and a once-per-frame `frame_end` strobe. `frame_end` marks the instant at which RTC digits may be re-latched without tearing.

## Interface
- `CLK_DIV`, default 4: system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); must be ≥2.
- `H_DISP` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing in pixels.
- `V_DISP` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing in lines.
- `CLK` in 1: system clock, 100 MHz.
- `RESET_N` in 1: asynchronous, active-low reset.
- `p_tick` out 1: one-CLK pulse per pixel period.
- `pix_x` out 10: current horizontal count, 0..H_TOTAL-1.
- `pix_y` out 10: current vertical count, 0..V_TOTAL-1.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `video_on` out 1: high when `pix_x` < H_DISP and `pix_y` < V_DISP.
- `frame_end` out 1: one-CLK pulse during the last pixel of each frame.

## Operation
- Derived constants:
  - H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP = 525.
  - Both totals must be ≤ 1024; elaboration fails otherwise.
- Divider:
  - Counter `div_cnt` runs 0..CLK_DIV-1 and wraps.
  - `p_tick` = (`div_cnt` == CLK_DIV-1), decoded from the register.
- Horizontal counter `h_cnt`:
  - Advances only in a CLK cycle where `p_tick` is high.
  - Wraps H_TOTAL-1 → 0.
- Vertical counter `v_cnt`:
  - Advances only when `p_tick` is high and `h_cnt` == H_TOTAL-1.
  - Wraps V_TOTAL-1 → 0.
  - When both counters are at their maximum, both wrap to 0 on the same edge.
- Outputs:
  - `pix_x` = `h_cnt`; `pix_y` = `v_cnt` (direct register outputs).
  - `hsync` and `vsync` are registers, loaded on the same edge as the counters with values decoded from the next counts. They therefore always correspond to the current `pix_x`/`pix_y`.
  - `hsync` is low iff `pix_x` ∈ [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1] = [656, 751].
  - `vsync` is low iff `pix_y` ∈ [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1] = [490, 491].
  - `video_on` is registered with the same next-count decode.
  - `frame_end` = `p_tick` & (`h_cnt` == 799) & (`v_cnt` == 524), combinational from registers.
- Reset, asynchronous:
  - `div_cnt`, `h_cnt` and `v_cnt` go to 0.
  - `hsync` = 1, `vsync` = 1, `video_on` = 1 (pixel 0,0 is visible).
  - `p_tick` = 0 and `frame_end` = 0.
  - Asserting reset mid-frame or mid-sync aborts immediately to these values; no partial sync pulse is completed.
  - After `RESET_N` rises, the first `p_tick` occurs CLK_DIV cycles later.

## Timing
- All registers are on `posedge CLK` with asynchronous clear on `negedge RESET_N`.
- `p_tick`:
  - Period CLK_DIV cycles, duty 1/CLK_DIV.
  - Zero latency from `div_cnt`.
- `pix_x`/`pix_y`/`hsync`/`vsync`/`video_on`:
  - Change only on the CLK edge that ends a `p_tick` cycle.
  - Stable for CLK_DIV cycles between changes.
- Line = 800 pixel periods = 3200 CLK; frame = 525 lines = 1,680,000 CLK.
- `hsync` low for 96 pixels (384 CLK); `vsync` low for 2 lines (6400 CLK).
- `frame_end`:
  - High for exactly one CLK per frame.
  - Coincides with the `p_tick` that wraps both counters to 0.
- Downstream stages (the text generator) add their own pipeline delay. This block does not compensate for that delay.

## Structure
- Shared package `vga_pkg` holds:
  - the default timing constants listed above;
  - derived H_TOTAL and V_TOTAL;
  - the sync-window bounds;
  - the 10-bit coordinate width.
- One sub-module: `divisor_pixel`, holding the CLK_DIV counter and producing `p_tick`. Horizontal/vertical counters and the output decode stay in the top.

## Test plan
- Reset values:
  - Hold `RESET_N` = 0 → `pix_x` = 0, `pix_y` = 0, `hsync` = 1, `vsync` = 1, `video_on` = 1, `p_tick` = 0, `frame_end` = 0.
  - Release `RESET_N` → first `p_tick` at CLK 4; `pix_x` = 1 after that edge.
- `p_tick` spacing: free run 1000 CLK → exactly 250 `p_tick` pulses, spaced 4 CLK apart.
- Horizontal line:
  - Across one line, `hsync` falls when `pix_x` becomes 656 and rises when `pix_x` becomes 752.
  - `video_on` falls at `pix_x` = 640 and rises again at `pix_x` = 0 of the next line.
  - `pix_y` increments exactly when `pix_x` goes 799 → 0.
- Vertical frame:
  - `vsync` is low only for `pix_y` 490–491.
  - `video_on` = 0 for all of `pix_y` 480–524.
  - `frame_end` pulses once per frame; consecutive pulses are exactly 1,680,000 CLK apart.
  - Counters wrap to (0,0) on the edge after `frame_end`.
- Reset during sync:
  - Pull `RESET_N` low at `pix_x` = 700, `pix_y` = 491 (both syncs low).
  - `hsync`/`vsync` go to 1 and the counters go to 0 without waiting for a clock edge.
  - Normal timing resumes after release.
- Parameter override: CLK_DIV = 2 → `p_tick` every 2 CLK; frame = 840,000 CLK; sync windows in pixel units are unchanged.
